// File: rtl/next_address.sv
// Next-PC generator: selects sequential, PC-relative branch, absolute jump or
// register jump target and registers the result on incr_pc.
module next_address (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        msb,
    input  logic [15:0] branch_label,
    input  logic [2:0]  brtype,
    input  logic [31:0] jmp_ra,
    input  logic [25:0] jmp_label,
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    output logic [31:0] incr_pc
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_ALW  = 3'd1,
        BR_LTZ  = 3'd2,
        BR_Z    = 3'd3,
        BR_NZ   = 3'd4,
        BR_CY   = 3'd5,
        BR_NCY  = 3'd6,
        BR_RSV  = 3'd7
    } br_kind_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_JMP  = 2'd1,
        SEL_REG  = 2'd2,
        SEL_RSV  = 2'd3
    } pc_src_e;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        take;
    logic [31:0] next;

    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + {{14{branch_label[15]}}, branch_label, 2'b00};
    assign jmp_target = {pc_plus4[31:28], jmp_label, 2'b00};

    always_comb begin
        take = 1'b0;
        case (br_kind_e'(brtype))
            BR_ALW:  take = 1'b1;
            BR_LTZ:  take = msb;
            BR_Z:    take = zero_flag;
            BR_NZ:   take = ~zero_flag;
            BR_CY:   take = carry_flag;
            BR_NCY:  take = ~carry_flag;
            default: take = 1'b0;
        endcase
    end

    // Reserved select code falls through to the sequential/branch path.
    always_comb begin
        next = take ? br_target : pc_plus4;
        case (pc_src_e'(pc_sel))
            SEL_JMP: next = jmp_target;
            SEL_REG: next = jmp_ra;
            default: next = take ? br_target : pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incr_pc <= '0;
        end else begin
            incr_pc <= next;
        end
    end

endmodule

// File: tb/tb_next_address.sv
// Self-checking bench for next_address: directed spec vectors plus random
// vectors, expected values queued at drive time and popped after the edge.
module tb_next_address;

    logic        clk;
    logic        rst_n;
    logic        zero_flag;
    logic        carry_flag;
    logic        msb;
    logic [15:0] branch_label;
    logic [2:0]  brtype;
    logic [31:0] jmp_ra;
    logic [25:0] jmp_label;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic [31:0] incr_pc;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    next_address dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .zero_flag    (zero_flag),
        .carry_flag   (carry_flag),
        .msb          (msb),
        .branch_label (branch_label),
        .brtype       (brtype),
        .jmp_ra       (jmp_ra),
        .jmp_label    (jmp_label),
        .pc           (pc),
        .pc_sel       (pc_sel),
        .incr_pc      (incr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference next-PC, written from the behavioural description.
    function automatic logic [31:0] model(input logic [1:0] sel, input logic [2:0] bt,
                                          input logic [15:0] lbl, input logic [31:0] ra,
                                          input logic [25:0] jl, input logic [31:0] p,
                                          input logic z, input logic c, input logic m);
        logic [31:0] p4;
        int          off;
        logic        t;
        p4  = p + 32'd4;
        off = int'($signed(lbl)) * 4;
        if (sel == 2'd1) return {p4[31:28], jl, 2'b00};
        if (sel == 2'd2) return ra;
        case (bt)
            3'd1:    t = 1'b1;
            3'd2:    t = m;
            3'd3:    t = z;
            3'd4:    t = !z;
            3'd5:    t = c;
            3'd6:    t = !c;
            default: t = 1'b0;
        endcase
        return t ? p4 + 32'(off) : p4;
    endfunction

    // Drive one cycle of inputs, queue the expected result, compare after the edge.
    task automatic drive(input string tag, input logic [1:0] sel, input logic [2:0] bt,
                         input logic [15:0] lbl, input logic [31:0] ra, input logic [25:0] jl,
                         input logic [31:0] p, input logic z, input logic c, input logic m,
                         input logic [31:0] exp);
        pc_sel = sel; brtype = bt; branch_label = lbl; jmp_ra = ra;
        jmp_label = jl; pc = p; zero_flag = z; carry_flag = c; msb = m;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check_eq(tag_q.pop_front(), incr_pc, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] r_ra, r_pc;
        logic [15:0] r_lbl;
        logic [25:0] r_jl;
        logic [2:0]  r_bt;
        logic [1:0]  r_sel;
        logic        r_z, r_c, r_m, cond;

        rst_n = 1'b1;
        zero_flag = 1'b0; carry_flag = 1'b0; msb = 1'b0;
        branch_label = '0; brtype = '0; jmp_ra = '0; jmp_label = '0;
        pc = '0; pc_sel = '0;

        // Asynchronous reset between edges, held over two edges, released mid-cycle.
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", incr_pc, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check_eq("reset_hold", incr_pc, 32'h0);
        #2 rst_n = 1'b1;
        #1 check_eq("reset_release_midcycle", incr_pc, 32'h0);

        drive("seq_pc0", 2'd0, 3'd0, 16'd0, 32'd0, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd4);
        drive("seq_wrap", 2'd0, 3'd0, 16'd0, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
        drive("jmp_label", 2'd1, 3'd0, 16'd0, 32'd0, 26'd26, 32'h0, 1'b0, 1'b0, 1'b0, 32'd104);
        drive("jmp_label_flags", 2'd1, 3'd1, 16'd71, 32'd5, 26'd26, 32'h0, 1'b1, 1'b1, 1'b1, 32'd104);
        drive("jmp_label_hibits", 2'd1, 3'd0, 16'd0, 32'd0, 26'h3FF_FFFF, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 32'hAFFF_FFFC);
        drive("jmp_reg", 2'd2, 3'd3, 16'd71, 32'd1045, 26'd26, 32'h0, 1'b1, 1'b1, 1'b0, 32'd1045);
        drive("br_always", 2'd0, 3'd1, 16'd71, 32'd0, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd288);
        drive("br_negative", 2'd0, 3'd1, 16'hFFFF, 32'd0, 26'd0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h100);

        for (int unsigned sel3 = 0; sel3 < 2; sel3++) begin
            for (int unsigned bt = 2; bt <= 7; bt++) begin
                for (int unsigned f = 0; f < 2; f++) begin
                    cond = (bt == 7) ? 1'b0 : ((bt == 4 || bt == 6) ? (f == 0) : (f == 1));
                    drive($sformatf("cond_sel%0d_bt%0d_f%0d", sel3 ? 3 : 0, bt, f),
                          sel3 ? 2'd3 : 2'd0, 3'(bt), 16'd71, 32'd0, 26'd0, 32'h0,
                          1'(f), 1'(f), 1'(f), cond ? 32'd288 : 32'd4);
                end
            end
        end

        // Isolate each flag: only the selected condition's flag may matter.
        drive("bz_carry_only", 2'd0, 3'd3, 16'd71, 32'd0, 26'd0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd4);
        drive("bcy_zero_only", 2'd0, 3'd5, 16'd71, 32'd0, 26'd0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd4);
        drive("bltz_msb_only", 2'd0, 3'd2, 16'd71, 32'd0, 26'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'd4);

        for (int unsigned i = 0; i < 60; i++) begin
            r_sel = 2'($urandom_range(0, 3)); r_bt = 3'($urandom_range(0, 7));
            r_lbl = 16'($urandom); r_ra = $urandom; r_jl = 26'($urandom);
            r_pc = $urandom; r_z = 1'($urandom); r_c = 1'($urandom); r_m = 1'($urandom);
            drive($sformatf("rand_%0d", i), r_sel, r_bt, r_lbl, r_ra, r_jl, r_pc, r_z, r_c, r_m,
                  model(r_sel, r_bt, r_lbl, r_ra, r_jl, r_pc, r_z, r_c, r_m));
        end

        // Reset asserted mid-cycle while the register holds a nonzero value.
        drive("pre_reset_load", 2'd2, 3'd0, 16'd0, 32'hDEAD_BEEF, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async_nonzero", incr_pc, 32'h0);
        @(posedge clk); #1;
        check_eq("reset_hold_edge", incr_pc, 32'h0);
        #1 rst_n = 1'b1;
        drive("after_reset", 2'd0, 3'd0, 16'd0, 32'd0, 26'd0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h44);

        if (exp_q.size() != 0) check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
